// File: rtl/modular_multiplier_pipe.sv
// modular_multiplier_pipe: 4-stage Barrett modular multiplier, c = (a*b) mod q.
// The modulus (q, mu) is picked per operation from a programmable table.
// Valid/ready flow control uses one global enable, and a tag travels alongside each operation.
module modular_multiplier_pipe #(
    parameter int WIDTH      = 30,
    parameter int NUM_MODULI = 4,
    parameter int IDX_W      = 2,
    parameter int TAG_W      = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [WIDTH-1:0] cfg_q,
    input  logic [WIDTH:0]   cfg_mu,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [IDX_W-1:0] in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_c,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    // Modulus table
    logic [WIDTH-1:0] r_tbl_q  [NUM_MODULI];
    logic [WIDTH:0]   r_tbl_mu [NUM_MODULI];

    // Stage 1: product, selected modulus
    logic               r_s1_valid;
    logic [2*WIDTH-1:0] r_s1_x;
    logic [WIDTH-1:0]   r_s1_q;
    logic [WIDTH:0]     r_s1_mu;
    logic [TAG_W-1:0]   r_s1_tag;
    logic               r_s1_err;

    // Stage 2: quotient estimate
    logic               r_s2_valid;
    logic [WIDTH:0]     r_s2_qe;
    logic [WIDTH+1:0]   r_s2_xl;
    logic [WIDTH-1:0]   r_s2_q;
    logic [TAG_W-1:0]   r_s2_tag;
    logic               r_s2_err;

    // Stage 3: partial remainder (< 3q)
    logic               r_s3_valid;
    logic [WIDTH+1:0]   r_s3_r;
    logic [WIDTH-1:0]   r_s3_q;
    logic [TAG_W-1:0]   r_s3_tag;
    logic               r_s3_err;

    // Stage 4: output registers
    logic               r_s4_valid;
    logic [WIDTH-1:0]   r_s4_c;
    logic [TAG_W-1:0]   r_s4_tag;
    logic               r_s4_err;

    logic               w_en;
    logic [WIDTH-1:0]   w_sel_q;
    logic [WIDTH:0]     w_sel_mu;
    logic [2*WIDTH-1:0] w_x;
    logic [WIDTH:0]     w_x_hi;
    logic [2*WIDTH+1:0] w_t;
    logic [WIDTH+1:0]   w_qeq;
    logic [WIDTH+1:0]   w_r;
    logic [WIDTH+1:0]   w_q_ext;
    logic [WIDTH+1:0]   w_r1;
    logic [WIDTH+1:0]   w_r2;
    logic               w_unused;

    assign w_en     = !r_s4_valid || out_ready;
    assign in_ready = w_en;

    assign w_sel_q  = r_tbl_q[in_sel];
    assign w_sel_mu = r_tbl_mu[in_sel];

    assign w_x    = {{WIDTH{1'b0}}, in_a} * {{WIDTH{1'b0}}, in_b};
    assign w_x_hi = r_s1_x[2*WIDTH-1:WIDTH-1];
    assign w_t    = {{(WIDTH+1){1'b0}}, w_x_hi} * {{(WIDTH+1){1'b0}}, r_s1_mu};

    // qe*q is only needed modulo 2^(WIDTH+2), so the product is formed at that width.
    assign w_qeq = {1'b0, r_s2_qe} * {2'b00, r_s2_q};
    assign w_r   = r_s2_xl - w_qeq;

    assign w_q_ext = {2'b00, r_s3_q};
    assign w_r1    = (r_s3_r >= w_q_ext) ? (r_s3_r - w_q_ext) : r_s3_r;
    assign w_r2    = (w_r1 >= w_q_ext) ? (w_r1 - w_q_ext) : w_r1;

    assign w_unused = ^{w_t[WIDTH:0], w_r2[WIDTH+1:WIDTH]};

    assign out_valid = r_s4_valid;
    assign out_c     = r_s4_c;
    assign out_tag   = r_s4_tag;
    assign out_err   = r_s4_err;

    // Table writes happen regardless of stalls; a reader in the same cycle sees the old entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tbl_q  <= '{default: '0};
            r_tbl_mu <= '{default: '0};
        end else if (cfg_we) begin
            r_tbl_q[cfg_idx]  <= cfg_q;
            r_tbl_mu[cfg_idx] <= cfg_mu;
        end
    end

    // S1: full product, and a snapshot of the selected modulus and tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            r_s1_q     <= '0;
            r_s1_mu    <= '0;
            r_s1_tag   <= '0;
            r_s1_err   <= 1'b0;
        end else if (w_en) begin
            r_s1_valid <= in_valid;
            r_s1_x     <= w_x;
            r_s1_q     <= w_sel_q;
            r_s1_mu    <= w_sel_mu;
            r_s1_tag   <= in_tag;
            r_s1_err   <= (w_sel_q == '0);
        end
    end

    // S2: Barrett quotient estimate qe = ((x >> (W-1)) * mu) >> (W+1)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_qe    <= '0;
            r_s2_xl    <= '0;
            r_s2_q     <= '0;
            r_s2_tag   <= '0;
            r_s2_err   <= 1'b0;
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            r_s2_qe    <= w_t[2*WIDTH+1:WIDTH+1];
            r_s2_xl    <= r_s1_x[WIDTH+1:0];
            r_s2_q     <= r_s1_q;
            r_s2_tag   <= r_s1_tag;
            r_s2_err   <= r_s1_err;
        end
    end

    // S3: partial remainder r = x - qe*q in WIDTH+2 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s3_valid <= 1'b0;
            r_s3_r     <= '0;
            r_s3_q     <= '0;
            r_s3_tag   <= '0;
            r_s3_err   <= 1'b0;
        end else if (w_en) begin
            r_s3_valid <= r_s2_valid;
            r_s3_r     <= w_r;
            r_s3_q     <= r_s2_q;
            r_s3_tag   <= r_s2_tag;
            r_s3_err   <= r_s2_err;
        end
    end

    // S4: up to two conditional subtractions; unconfigured entries report 0 with err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s4_valid <= 1'b0;
            r_s4_c     <= '0;
            r_s4_tag   <= '0;
            r_s4_err   <= 1'b0;
        end else if (w_en) begin
            r_s4_valid <= r_s3_valid;
            r_s4_c     <= r_s3_err ? '0 : w_r2[WIDTH-1:0];
            r_s4_tag   <= r_s3_tag;
            r_s4_err   <= r_s3_err;
        end
    end

endmodule

// File: tb/tb_modular_multiplier_pipe.sv
// Testbench for modular_multiplier_pipe: directed vectors, randomized traffic vs. a
// plain-arithmetic reference, backpressure, same-cycle table write, mid-flight reset.
module tb_modular_multiplier_pipe;

    localparam int W  = 30;
    localparam int NM = 4;
    localparam int IW = 2;
    localparam int TW = 12;
    localparam int SW = 14;

    localparam logic [W-1:0] QP = 30'd1073479681;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance (WIDTH=30)
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [W-1:0]  cfg_q;
    logic [W:0]    cfg_mu;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [IW-1:0] in_sel;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_c;
    logic [TW-1:0] out_tag;
    logic          out_err;

    // Small instance (WIDTH=14)
    logic          sm_cfg_we;
    logic [IW-1:0] sm_cfg_idx;
    logic [SW-1:0] sm_cfg_q;
    logic [SW:0]   sm_cfg_mu;
    logic          sm_in_valid;
    logic          sm_in_ready;
    logic [SW-1:0] sm_in_a;
    logic [SW-1:0] sm_in_b;
    logic [IW-1:0] sm_in_sel;
    logic [TW-1:0] sm_in_tag;
    logic          sm_out_valid;
    logic          sm_out_ready;
    logic [SW-1:0] sm_out_c;
    logic [TW-1:0] sm_out_tag;
    logic          sm_out_err;

    modular_multiplier_pipe #(
        .WIDTH(W), .NUM_MODULI(NM), .IDX_W(IW), .TAG_W(TW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_q(cfg_q), .cfg_mu(cfg_mu),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_sel(in_sel), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c),
        .out_tag(out_tag), .out_err(out_err)
    );

    modular_multiplier_pipe #(
        .WIDTH(SW), .NUM_MODULI(NM), .IDX_W(IW), .TAG_W(TW)
    ) dut_sm (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(sm_cfg_we), .cfg_idx(sm_cfg_idx), .cfg_q(sm_cfg_q), .cfg_mu(sm_cfg_mu),
        .in_valid(sm_in_valid), .in_ready(sm_in_ready), .in_a(sm_in_a), .in_b(sm_in_b),
        .in_sel(sm_in_sel), .in_tag(sm_in_tag),
        .out_valid(sm_out_valid), .out_ready(sm_out_ready), .out_c(sm_out_c),
        .out_tag(sm_out_tag), .out_err(sm_out_err)
    );

    typedef struct {
        logic [W-1:0]  c;
        logic [TW-1:0] tag;
        logic          err;
    } exp_t;

    typedef struct {
        logic [IW-1:0] sel;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [W-1:0]  c;
        logic          err;
    } vec_t;

    exp_t          sb[$];
    vec_t          vecs[7];
    logic [W-1:0]  mq[NM];
    logic [W:0]    mmu[NM];
    logic [TW-1:0] next_tag;
    int            n_checks = 0;
    int            n_errors = 0;
    int            bp_mode = 0;
    int            bp_cnt = 0;
    bit            seen_stall = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s", name);
    endfunction

    function automatic logic [W:0] calc_mu(input logic [W-1:0] q);
        logic [63:0] v;
        v = (64'd1 << (2 * W)) / {34'd0, q};
        return v[W:0];
    endfunction

    // Reference: plain modular arithmetic on the bench's own copy of the table
    function automatic exp_t model(input logic [IW-1:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        logic [63:0] p;
        e.tag = '0;
        if (mq[sel] == '0) begin
            e.c   = '0;
            e.err = 1'b1;
        end else begin
            p     = ({34'd0, a} * {34'd0, b}) % {34'd0, mq[sel]};
            e.c   = p[W-1:0];
            e.err = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [W-1:0] rand_q();
        logic [28:0] lo;
        lo = 29'($urandom_range(1, 32'h1FFF_FFFF));
        return {1'b1, lo};
    endfunction

    task automatic cfg_write(input logic [IW-1:0] idx, input logic [W-1:0] q, input logic [W:0] mu);
        cfg_we  = 1'b1;
        cfg_idx = idx;
        cfg_q   = q;
        cfg_mu  = mu;
        @(posedge clk); #1;
        cfg_we   = 1'b0;
        mq[idx]  = q;
        mmu[idx] = mu;
    endtask

    task automatic send(input logic [IW-1:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ec, input logic ee);
        bit   acc;
        exp_t e;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_sel   = sel;
        in_a     = a;
        in_b     = b;
        in_tag   = next_tag;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (acc) begin
            e.c   = ec;
            e.tag = next_tag;
            e.err = ee;
            sb.push_back(e);
            next_tag = next_tag + 1'b1;
        end else begin
            fail_now("accept_timeout");
        end
    endtask

    task automatic send_rand(input logic [IW-1:0] sel);
        logic [W-1:0] a;
        logic [W-1:0] b;
        exp_t         e;
        a = W'($urandom);
        b = W'($urandom);
        e = model(sel, a, b);
        send(sel, a, b, e.c, e.err);
    endtask

    task automatic drain();
        for (int k = 0; k < 400 && sb.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    // Consumer backpressure generator
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (bp_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = (bp_cnt % 3 == 0);
                    bp_cnt++;
                end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: scoreboard pop on transfer, hold-stability during stalls
    initial begin
        exp_t          e;
        bit            prev_stall;
        logic [W-1:0]  pc;
        logic [TW-1:0] pt;
        logic          pe;
        prev_stall = 1'b0;
        pc = '0;
        pt = '0;
        pe = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
                if (!in_ready) seen_stall = 1'b1;
                if (prev_stall) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_c", 64'(out_c), 64'(pc));
                    chk("hold_tag", 64'(out_tag), 64'(pt));
                    chk("hold_err", 64'(out_err), 64'(pe));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        fail_now("spurious_out");
                    end else begin
                        e = sb.pop_front();
                        chk("out_c", 64'(out_c), 64'(e.c));
                        chk("out_tag", 64'(out_tag), 64'(e.tag));
                        chk("out_err", 64'(out_err), 64'(e.err));
                    end
                end
                prev_stall = out_valid && !out_ready;
                pc = out_c;
                pt = out_tag;
                pe = out_err;
            end
        end
    end

    // Global time limit
    initial begin
        #2000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "time limit");
    end

    initial begin
        exp_t         e_old;
        exp_t         e_new;
        logic [W-1:0] nq;
        logic [W-1:0] a;
        logic [W-1:0] b;

        vecs[0] = '{sel: 2'd1, a: QP - 1, b: QP - 1, c: 30'd1,         err: 1'b0};
        vecs[1] = '{sel: 2'd1, a: 30'd12345, b: 30'd12345, c: 30'd152399025, err: 1'b0};
        vecs[2] = '{sel: 2'd3, a: 30'd5, b: 30'd7, c: 30'd0,           err: 1'b1};
        vecs[3] = '{sel: 2'd1, a: 30'd2, b: 30'd3, c: 30'd6,           err: 1'b0};
        vecs[4] = '{sel: 2'd1, a: 30'h3FFF_FFFF, b: 30'h3FFF_FFFF, c: 30'd15728580, err: 1'b0};
        vecs[5] = '{sel: 2'd1, a: 30'd0, b: 30'd12345, c: 30'd0,       err: 1'b0};
        vecs[6] = '{sel: 2'd1, a: QP, b: 30'd1, c: 30'd0,              err: 1'b0};

        for (int i = 0; i < NM; i++) begin
            mq[i]  = '0;
            mmu[i] = '0;
        end
        next_tag = 12'd1;
        cfg_we = 1'b0; cfg_idx = '0; cfg_q = '0; cfg_mu = '0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_sel = '0; in_tag = '0;
        sm_cfg_we = 1'b0; sm_cfg_idx = '0; sm_cfg_q = '0; sm_cfg_mu = '0;
        sm_in_valid = 1'b0; sm_in_a = '0; sm_in_b = '0; sm_in_sel = '0; sm_in_tag = '0;
        sm_out_ready = 1'b1;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_c", 64'(out_c), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // WIDTH=14: three back-to-back ops, results on cycles 4,5,6 after first accept
        sm_cfg_we = 1'b1; sm_cfg_idx = 2'd0; sm_cfg_q = 14'd12289; sm_cfg_mu = 15'd21843;
        @(posedge clk); #1;
        sm_cfg_we = 1'b0;
        sm_in_valid = 1'b1; sm_in_sel = 2'd0; sm_in_a = 14'd100; sm_in_b = 14'd1000; sm_in_tag = 12'd1;
        @(posedge clk); #1;
        sm_in_a = 14'd12288; sm_in_b = 14'd12288; sm_in_tag = 12'd2;
        @(posedge clk); #1;
        sm_in_a = 14'd16383; sm_in_b = 14'd16383; sm_in_tag = 12'd3;
        @(posedge clk); #1;
        sm_in_valid = 1'b0;
        chk("sm_lat_early", 64'(sm_out_valid), 64'd0);
        @(posedge clk); #1;
        chk("sm_v1", 64'(sm_out_valid), 64'd1);
        chk("sm_c1", 64'(sm_out_c), 64'd1688);
        chk("sm_tag1", 64'(sm_out_tag), 64'd1);
        chk("sm_err1", 64'(sm_out_err), 64'd0);
        @(posedge clk); #1;
        chk("sm_v2", 64'(sm_out_valid), 64'd1);
        chk("sm_c2", 64'(sm_out_c), 64'd1);
        chk("sm_tag2", 64'(sm_out_tag), 64'd2);
        @(posedge clk); #1;
        chk("sm_v3", 64'(sm_out_valid), 64'd1);
        chk("sm_c3", 64'(sm_out_c), 64'd10929);
        chk("sm_tag3", 64'(sm_out_tag), 64'd3);
        @(posedge clk); #1;
        chk("sm_v_end", 64'(sm_out_valid), 64'd0);

        // Main instance table: entries 0..2 configured, entry 3 left empty
        cfg_write(2'd1, QP, calc_mu(QP));
        nq = rand_q();
        cfg_write(2'd0, nq, calc_mu(nq));
        nq = rand_q();
        cfg_write(2'd2, nq, calc_mu(nq));

        // Directed vector table
        bp_mode = 0;
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].err);
        end

        // Random traffic, full throughput
        for (int i = 0; i < 30; i++) send_rand(2'($urandom_range(0, 3)));
        drain();

        // Backpressure 1,0,0 pattern
        bp_mode = 1;
        seen_stall = 1'b0;
        for (int i = 0; i < 8; i++) send_rand(2'($urandom_range(0, 2)));
        drain();
        chk("stall_seen", 64'(seen_stall), 64'd1);

        // Random backpressure
        bp_mode = 2;
        for (int i = 0; i < 40; i++) send_rand(2'($urandom_range(0, 3)));
        drain();
        bp_mode = 0;
        @(posedge clk); #1;

        // Same-cycle table write and accept on entry 0
        a = W'($urandom) | 30'h2000_0000;
        b = W'($urandom) | 30'h2000_0000;
        e_old = model(2'd0, a, b);
        nq = rand_q();
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_q = nq; cfg_mu = calc_mu(nq);
        send(2'd0, a, b, e_old.c, e_old.err);
        cfg_we = 1'b0;
        mq[0]  = nq;
        mmu[0] = calc_mu(nq);
        e_new = model(2'd0, a, b);
        send(2'd0, a, b, e_new.c, e_new.err);
        drain();

        // Reset with operations in flight
        for (int i = 0; i < 5; i++) send_rand(2'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        sb.delete();
        for (int i = 0; i < NM; i++) begin
            mq[i]  = '0;
            mmu[i] = '0;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("no_stale", 64'(out_valid), 64'd0);
        end
        send(2'd1, 30'd12345, 30'd12345, 30'd0, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/modular_multiplier_pipe.md
Name: modular_multiplier_pipe

Overview:
- Parametrised, fully pipelined Barrett modular multiplier: c = (a*b) mod q, with a runtime-selectable modulus from an internal table of NUM_MODULI entries.
- Successor to the fixed-modulus multiplier. Adds valid/ready flow control, a sideband tag, error reporting and a programmable modulus table.
- Sits in the butterfly datapath of the NTT core. One product per cycle.

Parameters:
- WIDTH, 30, operand, modulus and result width in bits.
- NUM_MODULI, 4, number of modulus table entries (power of 2, ≥2).
- IDX_W, 2, log2(NUM_MODULI).
- TAG_W, 12, width of the sideband tag carried alongside each operation.

Ports:
- clk  in  1  clock, all state rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  write strobe for one modulus table entry.
- cfg_idx  in  IDX_W  table entry to write.
- cfg_q  in  WIDTH  modulus to store.
- cfg_mu  in  WIDTH+1  Barrett constant floor(2^(2*WIDTH)/q) to store.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid && in_ready.
- in_a  in  WIDTH  operand a.
- in_b  in  WIDTH  operand b.
- in_sel  in  IDX_W  modulus table index for this operation.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_c  out  WIDTH  result.
- out_tag  out  TAG_W  tag of the returned operation.
- out_err  out  1  operation used an unconfigured entry (q==0).

Behaviour:
- Reset (async, rst_n low):
  - All table entries set to q=0, mu=0.
  - All pipeline valid bits cleared.
  - out_valid=0, out_c=0, out_tag=0, out_err=0, in_ready=1.
- Pipeline: 4 registered stages, latency exactly 4 cycles from accept to out_valid when not stalled.
  - S1: x = a*b (2*WIDTH bits). Latch q and mu of in_sel, plus the tag.
  - S2: t = (x >> (WIDTH-1)) * mu.
  - S3: qe = t >> (WIDTH+1); r = x[WIDTH+1:0] - (qe*q)[WIDTH+1:0], computed in WIDTH+2 bits.
  - S4: subtract q while r ≥ q, at most twice (r < 3q guaranteed). Register out_c.
- Valid modulus range: 2^(WIDTH-1) < q < 2^WIDTH. Under that constraint the result is correct for any a, b < 2^WIDTH, including operands ≥ q.
- Flow control: single global enable en = !out_valid || out_ready.
  - All stages advance only when en=1; in_ready = en.
  - Bubbles are not collapsed.
  - Throughput is 1/cycle while out_ready is held high.
- Stall: while out_valid && !out_ready, out_c, out_tag and out_err hold stable. Nothing is lost or duplicated.
- Table writes: take effect on the clock edge of cfg_we.
  - q and mu are captured in S1, so operations already in flight are unaffected by later writes.
  - A write and an accept on the same cycle, same index: the operation uses the old value.
  - Writes are accepted regardless of stall.
- q==0 at accept: out_c=0 and out_err=1 for that operation; the pipeline continues normally. For all other operations out_err=0.
- Reset asserted mid-operation: all in-flight operations are discarded and the table is cleared. After release, out_valid stays 0 until a new accept reaches S4.
- mu is taken as supplied. The block does no consistency check between q and mu; a wrong mu gives undefined results, not an error.

Test Plan:
- WIDTH=14, entry 0 = q 12289, mu 21843. Accept (a=100, b=1000), (12288, 12288), (16383, 16383) back to back with out_ready=1 -> out_c = 1688, 1, 10929 on cycles 4, 5, 6 after the first accept; tags returned in order.
- WIDTH=30, entry 1 = q 1073479681, mu floor(2^60/q). Accept (1073479680, 1073479680), then (12345, 12345) -> out_c=1, then 152399025.
- Backpressure: stream 8 ops with out_ready toggled 1,0,0,1,… -> in_ready deasserts during stalls; out_c and out_tag stable while stalled; all 8 results delivered exactly once, in order, and match a reference model.
- Same-cycle cfg_we to entry 0 (new q) and accept with in_sel=0 -> that result uses the old q; the next accept uses the new q.
- Accept with in_sel pointing at an unwritten entry -> out_c=0, out_err=1. An adjacent configured op shows out_err=0.
- Assert rst_n low with 3 ops in flight -> out_valid=0 immediately; no stale results after release; the table reads back as unconfigured (out_err=1 on the next op).
